// File: rtl/l2_dispatch_pkg.sv
// Shared types and default geometry for the L2 dispatch front end.
// Holds the op_kind encoding and FSM states used by l2_dispatch.
package l2_dispatch_pkg;

    localparam int L2_N_CPU_DEF    = 2;
    localparam int OP_KIND_W       = 3;
    localparam int L2_SET_BITS_DEF = 8;
    localparam int L2_WAY_BITS_DEF = 3;

    typedef enum logic [OP_KIND_W-1:0] {
        OP_NONE       = 3'd0,
        OP_RSP        = 3'd1,
        OP_FWD        = 3'd2,
        OP_FLUSH_STEP = 3'd3,
        OP_CPU        = 3'd4
    } l2_dispatch_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } l2_dispatch_state_t;

endpackage

// File: rtl/l2_rr_arbiter.sv
// CPU request arbiter: one-hot grant plus encoded id, combinational from req/en.
// Latency: 0 cycles (grant same cycle). Backpressure: en=0 suppresses every grant.
// L2_DISPATCH_RR_EN selects round-robin (with pointer) over fixed lowest-index priority.
module l2_rr_arbiter #(
    parameter int N       = 2,
    parameter int ID_BITS = 1
) (
`ifdef L2_DISPATCH_RR_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic [N-1:0]       req,
    input  logic               en,
    output logic [N-1:0]       gnt,
    output logic [ID_BITS-1:0] id
);

`ifdef L2_DISPATCH_RR_EN
    logic [ID_BITS-1:0] ptr;
    logic [ID_BITS:0]   sum;
    logic [ID_BITS-1:0] idx;
    logic               found;

    // Search starts at the pointer and wraps, so the last winner goes to the back.
    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (ID_BITS+1)'(k);
            if (sum >= (ID_BITS+1)'(N))
                sum = sum - (ID_BITS+1)'(N);
            idx = sum[ID_BITS-1:0];
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            ptr <= '0;
        else if (|gnt)
            ptr <= (id == ID_BITS'(N-1)) ? '0 : id + 1'b1;
    end
`else
    logic found;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                id     = ID_BITS'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/l2_dispatch.sv
// L2 front-end scheduler: arbitrates RSP > FWD > flush step > flush accept > CPU, runs flush sweep.
// Latency: accepted input appears as registered op next cycle. Backpressure: no grants while op held and !pipe_ready.
// Build option L2_DISPATCH_RR_EN makes CPU arbitration round-robin instead of fixed priority.
module l2_dispatch
    import l2_dispatch_pkg::*;
#(
    parameter int N_CPU    = L2_N_CPU_DEF,
    parameter int SETS     = 1 << L2_SET_BITS_DEF,
    parameter int WAYS     = 1 << L2_WAY_BITS_DEF,
    localparam int SET_BITS = $clog2(SETS),
    localparam int WAY_BITS = $clog2(WAYS),
    localparam int ID_BITS  = (N_CPU > 1) ? $clog2(N_CPU) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rsp_valid,
    output logic                 rsp_ready,
    input  logic                 fwd_valid,
    output logic                 fwd_ready,
    input  logic [N_CPU-1:0]     cpu_valid,
    output logic [N_CPU-1:0]     cpu_ready,
    input  logic                 flush_valid,
    output logic                 flush_ready,
    input  logic                 flush_all,
    input  logic                 fwd_stall,
    input  logic                 set_conflict,
    input  logic                 evict_stall,
    input  logic                 pipe_ready,
    output logic                 op_valid,
    output logic [OP_KIND_W-1:0] op_kind,
    output logic [ID_BITS-1:0]   op_cpu_id,
    output logic [SET_BITS-1:0]  op_set,
    output logic [WAY_BITS-1:0]  op_way,
    output logic                 op_flush_all,
    output logic                 flush_done
);

    l2_dispatch_state_t state;
    l2_dispatch_op_t    op_kind_q;
    l2_dispatch_op_t    next_kind;
    logic [SET_BITS-1:0] set_cnt;
    logic [WAY_BITS-1:0] way_cnt;

    logic load, hi_busy;
    logic gnt_rsp, gnt_fwd, gnt_step, gnt_flush, cpu_en;
    logic [N_CPU-1:0]   cpu_gnt;
    logic [ID_BITS-1:0] cpu_id;

    // Every grant is qualified by rst so no ready leaks out while in reset.
    assign load      = rst && (!op_valid || pipe_ready);
    assign hi_busy   = rsp_valid || (fwd_valid && !fwd_stall);
    assign gnt_rsp   = load && rsp_valid;
    assign gnt_fwd   = load && !rsp_valid && fwd_valid && !fwd_stall;
    assign gnt_step  = load && !hi_busy && (state == ST_FLUSH);
    assign gnt_flush = load && !hi_busy && (state == ST_IDLE) && flush_valid;
    assign cpu_en    = load && !hi_busy && (state == ST_IDLE) && !flush_valid
                       && !set_conflict && !evict_stall;

    l2_rr_arbiter #(.N(N_CPU), .ID_BITS(ID_BITS)) u_arb (
`ifdef L2_DISPATCH_RR_EN
        .clk (clk),
        .rst (rst),
`endif
        .req (cpu_valid),
        .en  (cpu_en),
        .gnt (cpu_gnt),
        .id  (cpu_id)
    );

    assign rsp_ready   = gnt_rsp;
    assign fwd_ready   = gnt_fwd;
    assign flush_ready = gnt_flush;
    assign cpu_ready   = cpu_gnt;
    assign op_kind     = op_kind_q;

    always_comb begin
        next_kind = OP_NONE;
        if (gnt_rsp)
            next_kind = OP_RSP;
        else if (gnt_fwd)
            next_kind = OP_FWD;
        else if (gnt_step)
            next_kind = OP_FLUSH_STEP;
        else if (|cpu_gnt)
            next_kind = OP_CPU;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            op_valid     <= 1'b0;
            op_kind_q    <= OP_NONE;
            op_cpu_id    <= '0;
            op_set       <= '0;
            op_way       <= '0;
            op_flush_all <= 1'b0;
            flush_done   <= 1'b0;
            set_cnt      <= '0;
            way_cnt      <= '0;
        end else begin
            flush_done <= 1'b0;
            if (load) begin
                op_valid  <= (next_kind != OP_NONE);
                op_kind_q <= next_kind;
                op_cpu_id <= (|cpu_gnt) ? cpu_id : '0;
                op_set    <= gnt_step ? set_cnt : '0;
                op_way    <= gnt_step ? way_cnt : '0;
            end
            if (gnt_flush) begin
                op_flush_all <= flush_all;
                set_cnt      <= '0;
                way_cnt      <= '0;
                state        <= ST_FLUSH;
            end
            // Way walks first; the last set/way ends the sweep without advancing the set.
            if (gnt_step) begin
                if (way_cnt == WAY_BITS'(WAYS-1)) begin
                    way_cnt <= '0;
                    if (set_cnt == SET_BITS'(SETS-1)) begin
                        set_cnt    <= '0;
                        flush_done <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        set_cnt <= set_cnt + 1'b1;
                    end
                end else begin
                    way_cnt <= way_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_dispatch.sv
// Directed bench for l2_dispatch at SETS=4, WAYS=2, N_CPU=2; honours L2_DISPATCH_RR_EN.
module tb_l2_dispatch;

    logic       clk = 1'b0;
    logic       rst;
    logic       rsp_valid, rsp_ready, fwd_valid, fwd_ready;
    logic [1:0] cpu_valid, cpu_ready;
    logic       flush_valid, flush_ready, flush_all;
    logic       fwd_stall, set_conflict, evict_stall, pipe_ready;
    logic       op_valid, op_flush_all, flush_done;
    logic [2:0] op_kind;
    logic [0:0] op_cpu_id;
    logic [1:0] op_set;
    logic [0:0] op_way;

    int tests = 0;
    int fails = 0;

`ifdef L2_DISPATCH_RR_EN
    localparam logic [1:0] CYC4_GNT = 2'b10;
    localparam logic [0:0] CYC4_ID  = 1'b1;
`else
    localparam logic [1:0] CYC4_GNT = 2'b01;
    localparam logic [0:0] CYC4_ID  = 1'b0;
`endif

    always #5 clk = ~clk;

    l2_dispatch #(.N_CPU(2), .SETS(4), .WAYS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .fwd_valid    (fwd_valid),
        .fwd_ready    (fwd_ready),
        .cpu_valid    (cpu_valid),
        .cpu_ready    (cpu_ready),
        .flush_valid  (flush_valid),
        .flush_ready  (flush_ready),
        .flush_all    (flush_all),
        .fwd_stall    (fwd_stall),
        .set_conflict (set_conflict),
        .evict_stall  (evict_stall),
        .pipe_ready   (pipe_ready),
        .op_valid     (op_valid),
        .op_kind      (op_kind),
        .op_cpu_id    (op_cpu_id),
        .op_set       (op_set),
        .op_way       (op_way),
        .op_flush_all (op_flush_all),
        .flush_done   (flush_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_step(input string tag, input int s, input int w, input logic done);
        chk({tag, "_valid"}, 32'(op_valid), 32'd1);
        chk({tag, "_kind"},  32'(op_kind),  32'd3);
        chk({tag, "_set"},   32'(op_set),   32'(s));
        chk({tag, "_way"},   32'(op_way),   32'(w));
        chk({tag, "_done"},  32'(flush_done), 32'(done));
    endtask

    initial begin
        // Reset with every request asserted: nothing may be granted.
        rst = 1'b0; rsp_valid = 1'b1; fwd_valid = 1'b1; cpu_valid = 2'b11;
        flush_valid = 1'b1; flush_all = 1'b0; fwd_stall = 1'b0;
        set_conflict = 1'b0; evict_stall = 1'b0; pipe_ready = 1'b1;
        tick(); tick();
        chk("rst_op_valid", 32'(op_valid), 32'd0);
        chk("rst_op_kind", 32'(op_kind), 32'd0);
        chk("rst_op_cpu_id", 32'(op_cpu_id), 32'd0);
        chk("rst_op_set", 32'(op_set), 32'd0);
        chk("rst_op_way", 32'(op_way), 32'd0);
        chk("rst_op_flush_all", 32'(op_flush_all), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        chk("rst_fwd_ready", 32'(fwd_ready), 32'd0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_flush_ready", 32'(flush_ready), 32'd0);

        // First RSP after reset: ready in cycle 0, op in cycle 1.
        fwd_valid = 1'b0; cpu_valid = 2'b00; flush_valid = 1'b0; rst = 1'b1;
        #1;
        chk("c0_rsp_ready", 32'(rsp_ready), 32'd1);
        tick();
        chk("c1_op_valid", 32'(op_valid), 32'd1);
        chk("c1_op_kind", 32'(op_kind), 32'd1);

        // Priority order RSP, FWD, CPU, CPU.
        fwd_valid = 1'b1; cpu_valid = 2'b11;
        #1;
        chk("pri_rsp_ready", 32'(rsp_ready), 32'd1);
        chk("pri_fwd_blocked", 32'(fwd_ready), 32'd0);
        tick();
        chk("pri_rsp_kind", 32'(op_kind), 32'd1);
        rsp_valid = 1'b0;
        #1;
        chk("pri_fwd_ready", 32'(fwd_ready), 32'd1);
        chk("pri_cpu_blocked", 32'(cpu_ready), 32'd0);
        tick();
        chk("pri_fwd_kind", 32'(op_kind), 32'd2);
        fwd_valid = 1'b0;
        #1;
        chk("pri_cpu0_ready", 32'(cpu_ready), 32'd1);
        tick();
        chk("pri_cpu0_kind", 32'(op_kind), 32'd4);
        chk("pri_cpu0_id", 32'(op_cpu_id), 32'd0);
        #1;
        chk("pri_cpu1_ready", 32'(cpu_ready), 32'(CYC4_GNT));
        tick();
        chk("pri_cpu1_kind", 32'(op_kind), 32'd4);
        chk("pri_cpu1_id", 32'(op_cpu_id), 32'(CYC4_ID));

        // Stall: hold an RSP op with pipe_ready low for 3 cycles.
        cpu_valid = 2'b00; rsp_valid = 1'b1;
        tick();
        chk("stall_load_kind", 32'(op_kind), 32'd1);
        rsp_valid = 1'b0; pipe_ready = 1'b0; fwd_valid = 1'b1; cpu_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_fwd_ready", 32'(fwd_ready), 32'd0);
            chk("stall_cpu_ready", 32'(cpu_ready), 32'd0);
            tick();
            chk("stall_op_valid", 32'(op_valid), 32'd1);
            chk("stall_op_kind", 32'(op_kind), 32'd1);
        end
        pipe_ready = 1'b1;
        #1;
        chk("unstall_fwd_ready", 32'(fwd_ready), 32'd1);
        tick();
        chk("unstall_fwd_kind", 32'(op_kind), 32'd2);
        fwd_valid = 1'b0;
        #1;
        chk("unstall_cpu_ready", 32'(cpu_ready), 32'd1);
        tick();
        chk("unstall_cpu_kind", 32'(op_kind), 32'd4);
        chk("unstall_cpu_id", 32'(op_cpu_id), 32'd0);

        // Full sweep with flush_all=1, an RSP inserted before step (1,1).
        flush_valid = 1'b1; flush_all = 1'b1; cpu_valid = 2'b11;
        #1;
        chk("sw1_flush_ready", 32'(flush_ready), 32'd1);
        chk("sw1_cpu_ready", 32'(cpu_ready), 32'd0);
        tick();
        flush_all = 1'b0;
        chk("sw1_accept_no_op", 32'(op_valid), 32'd0);
        chk("sw1_flush_all", 32'(op_flush_all), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                rsp_valid = 1'b1;
                #1;
                chk("sw1_ins_rsp_ready", 32'(rsp_ready), 32'd1);
                tick();
                rsp_valid = 1'b0;
                chk("sw1_ins_rsp_kind", 32'(op_kind), 32'd1);
            end
            #1;
            chk("sw1_cpu_ready", 32'(cpu_ready), 32'd0);
            chk("sw1_flush_busy", 32'(flush_ready), 32'd0);
            tick();
            chk_step("sw1_step", i / 2, i % 2, i == 7);
            chk("sw1_latched_all", 32'(op_flush_all), 32'd1);
        end

        // Waiting flush_valid is taken once IDLE; flush_done is a single pulse.
        #1;
        chk("sw2_flush_ready", 32'(flush_ready), 32'd1);
        chk("sw2_cpu_ready", 32'(cpu_ready), 32'd0);
        tick();
        flush_valid = 1'b0; cpu_valid = 2'b00;
        chk("sw2_done_pulse", 32'(flush_done), 32'd0);
        chk("sw2_accept_no_op", 32'(op_valid), 32'd0);
        chk("sw2_flush_all", 32'(op_flush_all), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_step("sw2_step", i / 2, i % 2, 1'b0);
        end

        // Reset where step (2,0) would be granted abandons the sweep.
        rst = 1'b0; flush_valid = 1'b1;
        tick();
        chk("abort_op_valid", 32'(op_valid), 32'd0);
        chk("abort_flush_done", 32'(flush_done), 32'd0);
        chk("abort_op_set", 32'(op_set), 32'd0);
        chk("abort_flush_ready_in_rst", 32'(flush_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_flush_ready_idle", 32'(flush_ready), 32'd1);
        tick();
        flush_valid = 1'b0;
        chk("abort_accept_no_done", 32'(flush_done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_step("sw3_step", i / 2, i % 2, i == 7);
        end
        tick();
        chk("sw3_done_clear", 32'(flush_done), 32'd0);
        chk("sw3_idle_no_op", 32'(op_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
